// File: rtl/cook_time_controller_if.sv
// rtl/cook_time_controller_if.sv - front-panel and down-counter signal bundle for cook_time_controller
//
// Buttons are one-cycle pulses from the debouncers. door_open is a level.
// timer_end is a level from the 1 Hz counter domain. load_*, start and
// timer_rst drive the down counter. heating, done_beep and state are
// front-panel / debug outputs.
//   slave  : the controller side (buttons in, counter controls out)
//   master : the panel/counter side (buttons out, counter controls in)
interface cook_time_controller_if;
    logic       btn_min_inc;
    logic       btn_sec_inc;
    logic       btn_add30;
    logic       btn_start;
    logic       btn_stop;
    logic       door_open;
    logic       timer_end;
    logic [5:0] load_minutes;
    logic [5:0] load_seconds;
    logic       start;
    logic       timer_rst;
    logic       heating;
    logic       done_beep;
    logic [2:0] state;

    modport slave (
        input  btn_min_inc, btn_sec_inc, btn_add30, btn_start, btn_stop,
        input  door_open, timer_end,
        output load_minutes, load_seconds, start, timer_rst, heating,
        output done_beep, state
    );

    modport master (
        output btn_min_inc, btn_sec_inc, btn_add30, btn_start, btn_stop,
        output door_open, timer_end,
        input  load_minutes, load_seconds, start, timer_rst, heating,
        input  done_beep, state
    );
endinterface

// File: rtl/cook_time_controller.sv
// rtl/cook_time_controller.sv - microwave front-panel cook time and run controller
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cook_time_controller_if.slave (buttons, door, timer_end in;
//           load_minutes/load_seconds, start, timer_rst, heating,
//           done_beep, state out)
// Parameters:
//   BEEP_CYCLES : done alert length in clk cycles
//   MAX_MIN     : highest settable minute value (<= 63)
module cook_time_controller #(
    parameter int BEEP_CYCLES = 100_000_000,
    parameter int MAX_MIN     = 59
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cook_time_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET    = 3'd1,
        COOK   = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int            CW        = $clog2(BEEP_CYCLES + 1);
    localparam logic [5:0]    MAXM      = 6'(MAX_MIN);
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q, prev_q, edge_q;
    logic          start_q, timer_rst_q, beep_q;

    // Candidate results of each edit, computed once and picked by the FSM.
    logic [6:0] sum30;
    logic [5:0] sec_inc_v, min_inc_v, add_min_v, add_sec_v;

    always_comb begin
        sum30     = {1'b0, sec_q} + 7'd30;
        sec_inc_v = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
        min_inc_v = (min_q >= MAXM) ? 6'd0 : min_q + 6'd1;
        if (sum30 < 7'd60) begin
            add_min_v = min_q;
            add_sec_v = sum30[5:0];
        end else if (min_q >= MAXM) begin
            // carry would overflow the minutes: pin at the maximum time
            add_min_v = MAXM;
            add_sec_v = 6'd59;
        end else begin
            add_min_v = min_q + 6'd1;
            add_sec_v = 6'(sum30 - 7'd60);
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.btn_add30) begin
                    min_d   = 6'd0;
                    sec_d   = 6'd30;
                    state_d = bus.door_open ? SET : COOK;
                end else if (bus.btn_min_inc) begin
                    min_d   = min_inc_v;
                    state_d = (min_inc_v == 6'd0) ? IDLE : SET;
                end else if (bus.btn_sec_inc) begin
                    sec_d   = sec_inc_v;
                    state_d = SET;
                end
            end
            SET: begin
                if (bus.btn_stop) begin
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                    state_d = IDLE;
                end else if (bus.btn_start && !bus.door_open) begin
                    state_d = COOK;
                end else if (bus.btn_add30) begin
                    min_d = add_min_v;
                    sec_d = add_sec_v;
                end else if (bus.btn_min_inc) begin
                    min_d   = min_inc_v;
                    state_d = (min_inc_v == 6'd0 && sec_q == 6'd0) ? IDLE : SET;
                end else if (bus.btn_sec_inc) begin
                    sec_d   = sec_inc_v;
                    state_d = (min_q == 6'd0 && sec_inc_v == 6'd0) ? IDLE : SET;
                end
            end
            COOK: begin
                if (bus.door_open || bus.btn_stop) begin
                    state_d = PAUSED;
                end else if (edge_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            PAUSED: begin
                if (bus.btn_stop) begin
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                    state_d = IDLE;
                end else if (bus.btn_start && !bus.door_open) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (bus.btn_stop || cnt_q == BEEP_LAST) begin
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                min_d   = 6'd0;
                sec_d   = 6'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            edge_q      <= 1'b0;
            start_q     <= 1'b0;
            timer_rst_q <= 1'b1;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            cnt_q       <= cnt_d;
            // two-flop synchronizer, then a registered rising-edge pulse
            sync1_q     <= bus.timer_end;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            edge_q      <= sync2_q & ~prev_q;
            start_q     <= (state_d == COOK);
            timer_rst_q <= !(state_d == COOK || state_d == PAUSED);
            beep_q      <= (state_d == DONE);
        end
    end

    assign bus.load_minutes = min_q;
    assign bus.load_seconds = sec_q;
    assign bus.start        = start_q;
    assign bus.timer_rst    = timer_rst_q;
    // door interlock backup: cut heating in the same cycle the door opens
    assign bus.heating      = start_q & ~bus.door_open;
    assign bus.done_beep    = beep_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_cook_time_controller.sv
// tb/tb_cook_time_controller.sv - randomized, model-checked bench for cook_time_controller
module tb_cook_time_controller;
    localparam int BEEP = 8;
    localparam int MAXM = 59;

    logic clk;
    logic rst_n;
    cook_time_controller_if bus ();

    cook_time_controller #(.BEEP_CYCLES(BEEP), .MAX_MIN(MAXM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // reference model: state number, time as min/sec, beep cycles remaining
    int m_state, m_min, m_sec, m_left;
    bit h[4]; // timer_end samples from 1..4 edges ago

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_min = 0; m_sec = 0; m_left = 0;
        for (int i = 0; i < 4; i++) h[i] = 1'b0;
    endtask

    task automatic clear_time();
        m_min = 0; m_sec = 0; m_state = 0;
    endtask

    task automatic model_edge();
        bit trig;
        int t;
        trig = h[2] && !h[3];
        for (int i = 3; i > 0; i--) h[i] = h[i-1];
        h[0] = bus.timer_end;
        case (m_state)
            0: begin
                if (bus.btn_add30) begin
                    m_min = 0; m_sec = 30;
                    m_state = bus.door_open ? 1 : 2;
                end else if (bus.btn_min_inc) begin
                    m_min = (m_min + 1) % (MAXM + 1);
                    m_state = (m_min * 60 + m_sec == 0) ? 0 : 1;
                end else if (bus.btn_sec_inc) begin
                    m_sec = (m_sec + 1) % 60;
                    m_state = (m_min * 60 + m_sec == 0) ? 0 : 1;
                end
            end
            1: begin
                if (bus.btn_stop) clear_time();
                else if (bus.btn_start && !bus.door_open) m_state = 2;
                else if (bus.btn_add30 || bus.btn_min_inc || bus.btn_sec_inc) begin
                    if (bus.btn_add30) begin
                        t = m_min * 60 + m_sec + 30;
                        if (t > MAXM * 60 + 59) t = MAXM * 60 + 59;
                        m_min = t / 60; m_sec = t % 60;
                    end else if (bus.btn_min_inc) m_min = (m_min + 1) % (MAXM + 1);
                    else m_sec = (m_sec + 1) % 60;
                    if (m_min * 60 + m_sec == 0) m_state = 0;
                end
            end
            2: begin
                if (bus.door_open || bus.btn_stop) m_state = 3;
                else if (trig) begin m_state = 4; m_left = BEEP; end
            end
            3: begin
                if (bus.btn_stop) clear_time();
                else if (bus.btn_start && !bus.door_open) m_state = 2;
            end
            default: begin
                if (bus.btn_stop) clear_time();
                else begin
                    m_left--;
                    if (m_left == 0) clear_time();
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state), 32'(m_state));
        chk("time", {bus.load_minutes, bus.load_seconds}, 32'(m_min * 64 + m_sec));
        chk("ctl", {bus.start, bus.timer_rst, bus.heating, bus.done_beep},
            {m_state == 2, !(m_state == 2 || m_state == 3),
             m_state == 2 && !bus.door_open, m_state == 4});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        bus.btn_min_inc = 0; bus.btn_sec_inc = 0; bus.btn_add30 = 0;
        bus.btn_start = 0; bus.btn_stop = 0;
    endtask

    // 0 min_inc, 1 sec_inc, 2 add30, 3 start, 4 stop
    task automatic press(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            case (which)
                0: bus.btn_min_inc = 1;
                1: bus.btn_sec_inc = 1;
                2: bus.btn_add30 = 1;
                3: bus.btn_start = 1;
                default: bus.btn_stop = 1;
            endcase
            step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_time", {bus.load_minutes, bus.load_seconds}, 0);
        chk("rst_ctl", {bus.start, bus.timer_rst, bus.heating, bus.done_beep}, 4'b0100);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int beeps;
        checks = 0; failures = 0;
        rst_n = 1;
        bus.btn_min_inc = 0; bus.btn_sec_inc = 0; bus.btn_add30 = 0;
        bus.btn_start = 0; bus.btn_stop = 0; bus.door_open = 0; bus.timer_end = 0;
        model_reset();
        #2;
        do_reset();

        press(1, 65);
        chk("sec65", {bus.load_minutes, bus.load_seconds}, {6'd0, 6'd5});
        chk("sec65_state", 32'(bus.state), 1);
        press(0, 61);
        chk("min61", {bus.load_minutes, bus.load_seconds}, {6'd1, 6'd5});
        press(4, 1);
        chk("stop_idle", 32'(bus.state), 0);

        press(2, 1);
        chk("add30_cook", {bus.state, bus.load_minutes, bus.load_seconds}, {3'd2, 6'd0, 6'd30});
        chk("add30_ctl", {bus.start, bus.timer_rst, bus.heating}, 3'b101);

        bus.door_open = 1;
        #1;
        chk("heat_gate", 32'(bus.heating), 0);
        step();
        chk("door_pause", {bus.state, bus.start, bus.load_minutes, bus.load_seconds},
            {3'd3, 1'b0, 6'd0, 6'd30});
        bus.door_open = 0;
        press(3, 1);
        chk("resume", 32'(bus.state), 2);

        bus.timer_end = 1;
        press(3, 3);
        chk("end_lat3", 32'(bus.state), 2);
        step();
        chk("end_done", 32'(bus.state), 4);
        beeps = 0;
        for (int k = 0; k < 20 && bus.done_beep; k++) begin
            beeps++;
            step();
        end
        bus.timer_end = 0;
        chk("beep_len", 32'(beeps), BEEP);
        chk("after_done", {bus.state, bus.load_minutes, bus.load_seconds, bus.timer_rst},
            {3'd0, 12'd0, 1'b1});

        press(0, 59);
        press(1, 45);
        chk("set5945", {bus.load_minutes, bus.load_seconds}, {6'd59, 6'd45});
        press(2, 2);
        chk("sat", {bus.load_minutes, bus.load_seconds}, {6'd59, 6'd59});
        press(3, 1);
        chk("sat_cook", 32'(bus.state), 2);
        press(4, 2);
        press(0, 1);
        bus.btn_start = 1;
        press(4, 1);
        chk("stop_wins", {bus.state, bus.load_minutes, bus.load_seconds}, 15'd0);
        press(2, 1);
        do_reset();

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) bus.door_open = ~bus.door_open;
            if ($urandom_range(0, 29) == 0) bus.timer_end = ~bus.timer_end;
            bus.btn_min_inc = ($urandom_range(0, 5) == 0);
            bus.btn_sec_inc = ($urandom_range(0, 4) == 0);
            bus.btn_add30   = ($urandom_range(0, 7) == 0);
            bus.btn_start   = ($urandom_range(0, 7) == 0);
            bus.btn_stop    = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
